// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants and FSM encoding for the instruction fetch unit
package if_fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_BUBBLE = '0;
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;
endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of {pc,inst} entries with flush; output reads zero when empty
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W = 2 * XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [W-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  assign do_pop = pop && cnt_q != '0;
  assign do_push = push && (cnt_q != (AW+1)'(DEPTH) || do_pop);
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
  assign valid = cnt_q != '0;
  assign count = cnt_q;
  assign dout = valid ? mem_q[rd_q] : '0;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-outstanding instruction fetcher feeding a small {pc,inst} buffer, with branch redirect
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  stall,
  input  logic        br,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] inst_if,
  output logic        if_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic drop_q, drop_d, push, pop, issue_ok;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  logic [2*XLEN-1:0] head;
  logic unused_stall;
  assign unused_stall = ^stall[4:2];
  // an in-flight response counts against capacity so a push can never overflow
  assign occ = {1'b0, count} + (CW+1)'(state_q == WAIT_RSP);
  assign issue_ok = !stall[0] && !br && !drop_q && occ < (CW+1)'(FIFO_DEPTH);
  assign pop = if_valid && !stall[1];
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d = req_pc_q;
    drop_d = drop_q;
    push = 1'b0;
    if (br) begin
      state_d = IDLE;
      fetch_pc_d = {br_target[XLEN-1:2], 2'b00};
      drop_d = (state_q == WAIT_GNT && imem_gnt) || ((state_q == WAIT_RSP || drop_q) && !imem_rvalid);
    end else begin
      case (state_q)
        IDLE: begin
          drop_d = drop_q && !imem_rvalid;
          state_d = issue_ok ? WAIT_GNT : IDLE;
        end
        WAIT_GNT: if (imem_gnt) begin
          state_d = WAIT_RSP;
          req_pc_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
        WAIT_RSP: if (imem_rvalid) begin
          push = 1'b1;
          state_d = issue_ok ? WAIT_GNT : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q <= req_pc_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(br),
    .push(push),
    .pop(pop),
    .din({req_pc_q, imem_rdata}),
    .dout(head),
    .valid(if_valid),
    .count(count)
  );
  assign imem_req = state_q == WAIT_GNT;
  assign imem_addr = fetch_pc_q;
  assign pc_if = head[2*XLEN-1:XLEN];
  assign inst_if = if_valid ? head[XLEN-1:0] : NOP_BUBBLE;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized and directed checks of if_fetch_unit against a program-order fetch model
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk = 0, reset = 1, br = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [4:0] stall = 0;
  logic [31:0] br_target = 0, imem_rdata = 0;
  logic imem_req, if_valid;
  logic [31:0] imem_addr, pc_if, inst_if;
  int n_chk = 0, n_fail = 0, pops = 0;
  bit pend = 0;
  logic [31:0] pa = 0;
  int pw = 0, lat_lo = 0, lat_hi = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br(br), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_if(pc_if), .inst_if(inst_if), .if_valid(if_valid)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // one clock; memory returns each granted word in order after lat_lo..lat_hi idle cycles
  task automatic cyc();
    logic g;
    logic [31:0] ga;
    g = imem_req && imem_gnt && !reset;
    ga = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 0;
    imem_rdata = $urandom;
    if (reset) pend = 0;
    else begin
      if (g) begin
        pend = 1;
        pa = ga;
        pw = $urandom_range(lat_hi, lat_lo);
      end
      if (pend) begin
        if (pw == 0) begin
          imem_rvalid = 1;
          imem_rdata = word(pa);
          pend = 0;
        end else pw--;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  // model: requests and consumed instructions each follow a sequential PC stream restarted by br
  logic [31:0] exp_fetch, exp_cons;
  logic p_hold, p_br, p_req, p_s0, first;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst req", imem_req, 0);
      chk("rst valid", if_valid, 0);
      chk("rst addr", imem_addr, RESET_PC);
      exp_fetch = RESET_PC;
      exp_cons = RESET_PC;
      p_hold = 0; p_br = 0; p_req = 0; p_s0 = 0; first = 1;
    end else begin
      if (first) chk("first req early", imem_req, 0);
      if (!if_valid) begin
        chk("empty pc", pc_if, 0);
        chk("empty inst", inst_if, 0);
      end else begin
        chk("head pc", pc_if, exp_cons);
        chk("head inst", inst_if, word(exp_cons));
      end
      if (imem_req) chk("req addr", imem_addr, exp_fetch);
      if (p_hold) chk("req held", imem_req, 1);
      if (p_br) chk("req after br", imem_req, 0);
      if (imem_req && !p_req) chk("issue allowed", {30'b0, p_s0, p_br}, 0);
      if (br) begin
        exp_fetch = {br_target[31:2], 2'b00};
        exp_cons = exp_fetch;
      end else begin
        if (imem_req && imem_gnt) exp_fetch += 4;
        if (if_valid && !stall[1]) begin
          exp_cons += 4;
          pops++;
        end
      end
      p_hold = imem_req && !imem_gnt && !br;
      p_br = br; p_req = imem_req; p_s0 = stall[0]; first = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    imem_gnt = 1;
    repeat (3) cyc();
    chk("t0 req", imem_req, 0);
    chk("t0 pc", pc_if, 0);
    chk("t0 inst", inst_if, 0);
    chk("t0 addr", imem_addr, RESET_PC);
    reset = 0;
    // sequential fetch from reset
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 10 && !if_valid; i++) cyc();
      chk("t35 pc", pc_if, 32'(k * 4));
      chk("t35 inst", inst_if, word(32'(k * 4)));
      cyc();
    end
    // consumer stall fills the buffer and stops issue
    stall = 5'b00010;
    repeat (5) cyc();
    chk("t36 req", imem_req, 0);
    chk("t36 valid", if_valid, 1);
    stall = 0;
    repeat (10) cyc();
    // redirect while the 0x8 response is outstanding
    lat_lo = 2; lat_hi = 2;
    do_reset();
    for (int i = 0; i < 30 && !(imem_req && imem_addr == 32'h8); i++) cyc();
    chk("t37 addr8", imem_addr, 32'h8);
    cyc();
    br = 1; br_target = 32'h100;
    cyc();
    br = 0;
    for (int i = 0; i < 30 && !if_valid; i++) cyc();
    chk("t37 pc", pc_if, 32'h100);
    // redirect coinciding with a response
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 20 && !imem_rvalid; i++) cyc();
    chk("t38 rvalid", imem_rvalid, 1);
    br = 1; br_target = 32'h200;
    cyc();
    br = 0;
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    chk("t38 addr", imem_addr, 32'h200);
    for (int i = 0; i < 20 && !if_valid; i++) cyc();
    chk("t38 pc", pc_if, 32'h200);
    // address wrap at the top of memory, unaligned target is word aligned
    br = 1; br_target = 32'hFFFF_FFFE;
    cyc();
    br = 0;
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    chk("t39 addr top", imem_addr, 32'hFFFF_FFFC);
    cyc();
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    chk("t39 addr wrap", imem_addr, 32'h0);
    // asynchronous reset while waiting for grant
    stall = 5'b00010;
    for (int i = 0; i < 20 && !if_valid; i++) cyc();
    imem_gnt = 0;
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    chk("t40 req before", imem_req, 1);
    chk("t40 valid before", if_valid, 1);
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("t40 req async", imem_req, 0);
    chk("t40 valid async", if_valid, 0);
    chk("t40 pc async", pc_if, 0);
    chk("t40 addr async", imem_addr, RESET_PC);
    cyc();
    cyc();
    stall = 0; imem_gnt = 1;
    reset = 0;
    for (int i = 0; i < 20 && !imem_req; i++) cyc();
    chk("t40 first addr", imem_addr, RESET_PC);
    // randomized traffic
    lat_lo = 0; lat_hi = 2;
    pops = 0;
    for (int n = 0; n < 3000; n++) begin
      stall = {3'($urandom), ($urandom % 3 == 0), ($urandom % 5 == 0)};
      br = ($urandom % 20 == 0);
      br_target = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      imem_gnt = ($urandom % 4 != 0);
      cyc();
    end
    chk("progress", {31'b0, pops > 100}, 1);
    br = 0; stall = 0;
    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
